// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter that lets two requesters share one SPI
// master. It runs one transfer at a time: accept, start strobe, wait for completion,
// one-cycle response, then a fixed idle gap before the next acceptance.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transfer that stays busy
// for TIMEOUT_CYCLES cycles. The abort answers with rdata=0xFF and err=1.
module spi_xfer_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned HOLDOFF_CYCLES = 52
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_wdata,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    output logic       rsp1_err,
    output logic       spi_tx_start,
    output logic       spi_rx_start,
    output logic [7:0] spi_tx_data,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_rx_valid,
    input  logic       spi_tx_done
);

    // A single counter serves both the busy timeout and the hold-off gap.
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES
                                                                         : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RESP,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;       // 1: requester 1 wins a tie
    logic               owner_q, owner_d;   // requester being served
    logic [1:0]         op_q, op_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rsp0_rdata_q, rsp0_rdata_d;
    logic [7:0]         rsp1_rdata_q, rsp1_rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
    logic               rsp0_err_q, rsp0_err_d;
    logic               rsp1_err_q, rsp1_err_d;
    logic               res_err;
`endif

    logic               grant;
    logic               res_load;
    logic [7:0]         res_rdata;
    logic [1:0]         sel_op;

    // With both requesters valid the pointer decides; otherwise the lone one wins.
    assign grant  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign sel_op = grant ? req1_op : req0_op;

    // Next-state, datapath capture and response loading.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        res_load     = 1'b0;
        res_rdata    = 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;
        res_err      = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_d = grant;
                    ptr_d   = ~grant;
                    op_d    = sel_op;
                    wdata_d = grant ? req1_wdata : req0_wdata;
                    cnt_d   = '0;
                    if (sel_op == 2'b00) begin
                        // A no-op answers immediately with zero data.
                        state_d  = S_RESP;
                        res_load = 1'b1;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_BUSY;
                cnt_d   = '0;
            end
            S_BUSY: begin
                if (spi_tx_done || spi_rx_valid) begin
                    state_d   = S_RESP;
                    res_load  = 1'b1;
                    res_rdata = op_q[1] ? spi_rx_data : 8'h00;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_RESP;
                    res_load  = 1'b1;
                    res_rdata = 8'hFF;
                    res_err   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = (op_q == 2'b00) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The owner's response registers change only on the edge into RESP, so
        // they stay stable between strobes.
        if (res_load) begin
            if (owner_d) begin
                rsp1_rdata_d = res_rdata;
`ifdef SPI_ARB_TIMEOUT_EN
                rsp1_err_d   = res_err;
`endif
            end else begin
                rsp0_rdata_d = res_rdata;
`ifdef SPI_ARB_TIMEOUT_EN
                rsp0_err_d   = res_err;
`endif
            end
        end
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            op_q         <= 2'b00;
            wdata_q      <= 8'h00;
            cnt_q        <= '0;
            rsp0_rdata_q <= 8'h00;
            rsp1_rdata_q <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
`endif
        end
    end

    // Ready is combinational in IDLE, but held low while reset is asserted.
    assign req0_ready = !reset && (state_q == S_IDLE) && req0_valid && !grant;
    assign req1_ready = !reset && (state_q == S_IDLE) && req1_valid &&  grant;

    assign spi_tx_start = (state_q == S_START) && op_q[0];
    assign spi_rx_start = (state_q == S_START) && op_q[1];
    assign spi_tx_data  = ((state_q == S_START) || (state_q == S_BUSY)) ? wdata_q : 8'h00;

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) &&  owner_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;
`else
    assign rsp0_err   = 1'b0;
    assign rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Testbench for spi_xfer_arbiter. Directed vectors and hand-written corner cases
// come first. Random transfers follow, checked against a transaction-level model:
// a round-robin pointer plus response and latency rules. Works in both builds,
// with and without SPI_ARB_TIMEOUT_EN.
module tb_spi_xfer_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned H  = 52;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_wdata, req1_wdata;
    logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       spi_tx_start, spi_rx_start, spi_rx_valid, spi_tx_done;
    logic [7:0] spi_tx_data, spi_rx_data;

    spi_xfer_arbiter #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(H)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_err(rsp1_err),
        .spi_tx_start(spi_tx_start), .spi_rx_start(spi_rx_start),
        .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
        .spi_rx_valid(spi_rx_valid), .spi_tx_done(spi_tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;   // model: requester that wins when both are valid

    typedef struct {
        logic       v0;
        logic       v1;
        logic [1:0] op0;
        logic [1:0] op1;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] rx;
        int         dly;        // busy cycles before the completion strobe
        logic       use_rx;     // completion via rx_valid instead of tx_done
        int         exp_grant;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic v0, input logic v1, input int ptr);
        if (v0 && v1) return ptr;
        return v0 ? 0 : 1;
    endfunction

    function automatic logic model_timed_out(input logic [1:0] op, input int dly);
        return TO_EN && (op != 2'b00) && (dly >= int'(TO));
    endfunction

    // One complete transfer from IDLE back to IDLE, checked cycle by cycle.
    task automatic xfer(input vec_t v);
        logic [1:0] op;
        logic [7:0] w;
        int         g;
        int         k;
        int         exp_k;
        g = v.exp_grant;
        @(negedge clk);
        req0_valid = v.v0;  req1_valid = v.v1;
        req0_op    = v.op0; req1_op    = v.op1;
        req0_wdata = v.w0;  req1_wdata = v.w1;
        #1;
        check("grant_ready0", req0_ready, g == 0);
        check("grant_ready1", req1_ready, g == 1);
        op = (g == 1) ? v.op1 : v.op0;
        w  = (g == 1) ? v.w1  : v.w0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        if (op == 2'b00) begin
            check("noop_no_start", {spi_tx_start, spi_rx_start}, 0);
        end else begin
            check("start_tx", spi_tx_start, op[0]);
            check("start_rx", spi_rx_start, op[1]);
            check("start_data", spi_tx_data, w);
            exp_k = model_timed_out(op, v.dly) ? int'(TO) + 1 : v.dly + 2;
            for (k = 1; k <= 200; k++) begin
                @(negedge clk);
                spi_rx_data  = v.rx;
                spi_tx_done  = (k == v.dly + 1) && !v.use_rx;
                spi_rx_valid = (k == v.dly + 1) &&  v.use_rx;
                #1;
                if (rsp0_valid || rsp1_valid) break;
                if (k == 1) check("busy_data", spi_tx_data, w);
            end
            spi_tx_done = 1'b0; spi_rx_valid = 1'b0;
            check("rsp_latency", k, exp_k);
            check("resp_tx_data_zero", spi_tx_data, 0);
        end
        check("rsp_owner_valid", (g == 1) ? rsp1_valid : rsp0_valid, 1);
        check("rsp_other_valid", (g == 1) ? rsp0_valid : rsp1_valid, 0);
        check("rsp_rdata", (g == 1) ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
        check("rsp_err", (g == 1) ? rsp1_err : rsp0_err, v.exp_err);
        if (op != 2'b00) begin
            for (int h = 0; h < int'(H); h++) begin
                @(negedge clk);
                req0_valid = 1'b1; req1_valid = 1'b1;
                #1;
                if (h == 0) begin
                    check("rsp_strobe_clear", {rsp0_valid, rsp1_valid}, 0);
                    check("rdata_held", (g == 1) ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
                end
                check("hold_quiet", {req0_ready, req1_ready, spi_tx_start, spi_rx_start}, 0);
            end
        end
        // First IDLE cycle: the other requester must now win a tie.
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("idle_ready0", req0_ready, g == 1);
        check("idle_ready1", req1_ready, g == 0);
        check("idle_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants[$];
        int   starts[$];
        int   n_rsp;
        logic pend;

        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b01; req1_op = 2'b01;
        req0_wdata = 8'h00; req1_wdata = 8'h00;
        spi_rx_data = 8'h00; spi_rx_valid = 1'b0; spi_tx_done = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 2'b01, 2'b00, 8'hA5, 8'h00, 8'h11, 3,  1'b0, 0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 2'b10, 8'h00, 8'h00, 8'h3C, 5,  1'b1, 1, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'b11, 2'b01, 8'h5A, 8'h77, 8'hC3, 0,  1'b0, 0, 8'hC3, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 2'b10, 8'h12, 8'h34, 8'h96, 2,  1'b1, 1, 8'h96, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 2'b01, 8'h44, 8'h00, 8'h99, 0,  1'b0, 0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 2'b11, 2'b00, 8'h00, 8'h55, 8'h99, 0,  1'b0, 1, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'b10, 2'b00, 8'h21, 8'h00, 8'hE7, 15, 1'b1, 0, 8'hE7, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 2'b00, 2'b01, 8'h00, 8'hC0, 8'h55, 40, 1'b0, 1,
                    TO_EN ? 8'hFF : 8'h00, TO_EN};

        // Reset state: every output low, even with both requests pending.
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", {req0_ready, req1_ready}, 0);
        check("reset_start", {spi_tx_start, spi_rx_start}, 0);
        check("reset_tx_data", spi_tx_data, 0);
        check("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("reset_rsp_data", {rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors; expected values are worked out by hand from reset.
        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i]);
            ptr_m = 1 - vecs[i].exp_grant;
        end

        // Reset while BUSY, then a stray completion: nothing may answer.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b01; req0_wdata = 8'h5A;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midreset_outputs", {req0_ready, req1_ready, spi_tx_start, spi_rx_start,
                                   rsp0_valid, rsp1_valid}, 0);
        check("midreset_tx_data", spi_tx_data, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        spi_tx_done = 1'b1; spi_rx_valid = 1'b1; spi_rx_data = 8'h77;
        #1;
        check("stray_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spi_tx_done = 1'b0; spi_rx_valid = 1'b0;
            #1;
            check("stray_quiet", {rsp0_valid, rsp1_valid, spi_tx_start, spi_rx_start}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("postreset_ptr_ready0", req0_ready, 1);
        check("postreset_ptr_ready1", req1_ready, 0);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        ptr_m = 0;

        // Both requesters held continuously: grants alternate, starts spaced apart.
        n_rsp = 0;
        pend  = 1'b0;
        req0_op = 2'b01; req1_op = 2'b01;
        req0_wdata = 8'hB0; req1_wdata = 8'hB1;
        for (int cyc = 0; cyc < 2000 && n_rsp < 4; cyc++) begin
            @(negedge clk);
            spi_tx_done = pend;
            pend = 1'b0;
            req0_valid = (grants.size() < 4);
            req1_valid = (grants.size() < 4);
            #1;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (spi_tx_start) begin
                starts.push_back(cyc);
                pend = 1'b1;
            end
            if (rsp0_valid || rsp1_valid) n_rsp++;
        end
        spi_tx_done = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("alt_rsp_count", n_rsp, 4);
        check("alt_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("alt_grant_order", grants[i], i % 2);
        for (int i = 1; i < starts.size(); i++)
            check("alt_start_gap_ok", (starts[i] - starts[i-1]) >= int'(H), 1);
        repeat (H + 3) @(negedge clk);
        ptr_m = 0;

        // Random transfers checked against the transaction-level model.
        for (int i = 0; i < 60; i++) begin
            vec_t       v;
            int         r;
            logic [1:0] op;
            logic       to;
            r        = $urandom_range(1, 3);
            v.v0     = r[0];
            v.v1     = r[1];
            v.op0    = 2'($urandom_range(0, 3));
            v.op1    = 2'($urandom_range(0, 3));
            v.w0     = 8'($urandom);
            v.w1     = 8'($urandom);
            v.rx     = 8'($urandom);
            v.dly    = $urandom_range(0, 24);
            v.use_rx = 1'($urandom_range(0, 1));
            v.exp_grant = model_grant(v.v0, v.v1, ptr_m);
            op = (v.exp_grant == 1) ? v.op1 : v.op0;
            to = model_timed_out(op, v.dly);
            v.exp_err   = to;
            v.exp_rdata = to ? 8'hFF : (op[1] ? v.rx : 8'h00);
            xfer(v);
            ptr_m = 1 - v.exp_grant;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
